movement_controller: RTL and testbench

- Sequences the runner's vertical-movement datapath (the y-updater FSM plus the y register).
- Generates the per-frame update strobe from the system clock and captures player key presses as rising edges.
- Issues exactly one one-hot operation pulse per action, then tracks the action's frame count and guards re-issue until the action has fully completed and settled.
- Checks on completion that the runner is back at ground level.

---
 rtl/movement_pkg.sv | 34 +++
 rtl/frame_tick_gen.sv | 31 +++
 rtl/movement_controller.sv | 135 +++++++++++++
 tb/tb_movement_controller.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/movement_pkg.sv
// rtl/movement_pkg.sv - shared types and constants for the runner movement controller
package movement_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ACT_NONE  = 2'b00,
    ACT_BIG   = 2'b01,
    ACT_SMALL = 2'b10,
    ACT_DROP  = 2'b11
  } action_t;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_BIG   = 3'b001;
  localparam logic [2:0] OP_SMALL = 3'b010;
  localparam logic [2:0] OP_DROP  = 3'b100;

  localparam logic [6:0] GROUND_Y_DEF = 7'd108;

  function automatic logic [2:0] op_of(input action_t a);
    case (a)
      ACT_BIG:   op_of = OP_BIG;
      ACT_SMALL: op_of = OP_SMALL;
      ACT_DROP:  op_of = OP_DROP;
      default:   op_of = OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - divides the system clock into a one-clk per-frame update strobe
module frame_tick_gen #(
  parameter int unsigned TICK_DIV = 833333
) (
  input  logic clk,
  input  logic reset,
  input  logic game_en,
  output logic update
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  if (TICK_DIV < 4 || TICK_DIV > (1 << 20)) begin : g_bad_div
    $fatal(1, "TICK_DIV out of range 4..2^20");
  end

  logic [CNT_W-1:0] cnt;

  // Counter freezes while paused so the frame phase survives a pause.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (game_en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign update = game_en && (cnt == LAST);

endmodule

// File: rtl/movement_controller.sv
// rtl/movement_controller.sv - sequences runner jump/drop actions against the frame strobe
module movement_controller
  import movement_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 833333,
  parameter int          BIG_LEN   = 10,
  parameter int          SMALL_LEN = 15,
  parameter int          DROP_LEN  = 9,
  parameter logic [6:0]  GROUND_Y  = GROUND_Y_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       game_en,
  input  logic       key_big,
  input  logic       key_small,
  input  logic       key_drop,
  input  logic [6:0] y_in,
  output logic       update,
  output logic [2:0] operation,
  output logic       busy,
  output logic [1:0] action,
  output logic [4:0] frames_left,
  output logic       land_err
);

  if (BIG_LEN < 1 || BIG_LEN > 31) begin : g_bad_big
    $fatal(1, "BIG_LEN out of range 1..31");
  end
  if (SMALL_LEN < 1 || SMALL_LEN > 31) begin : g_bad_small
    $fatal(1, "SMALL_LEN out of range 1..31");
  end
  if (DROP_LEN < 1 || DROP_LEN > 31) begin : g_bad_drop
    $fatal(1, "DROP_LEN out of range 1..31");
  end

  localparam logic [4:0] BIG_L   = 5'(BIG_LEN);
  localparam logic [4:0] SMALL_L = 5'(SMALL_LEN);
  localparam logic [4:0] DROP_L  = 5'(DROP_LEN);

  frame_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .game_en (game_en),
    .update  (update)
  );

  logic [2:0] keys, key_prev, rise, pend_sel;
  logic [2:0] pending, pending_next;
  state_t     state, state_next;
  action_t    act, act_next;
  logic [4:0] remain, remain_next;

  // Key vector bit order matches the one-hot operation encoding.
  assign keys = {key_drop, key_small, key_big};
  assign rise = keys & ~key_prev;

  always_comb begin
    pend_sel = OP_NONE;
    if (rise[2])      pend_sel = OP_DROP;
    else if (rise[0]) pend_sel = OP_BIG;
    else if (rise[1]) pend_sel = OP_SMALL;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_prev <= 3'b000;
      pending  <= 3'b000;
      state    <= ST_IDLE;
      act      <= ACT_NONE;
      remain   <= 5'd0;
    end else begin
      key_prev <= keys;
      pending  <= pending_next;
      state    <= state_next;
      act      <= act_next;
      remain   <= remain_next;
    end
  end

  always_comb begin
    state_next   = state;
    act_next     = act;
    remain_next  = remain;
    pending_next = pending;
    operation    = OP_NONE;
    land_err     = 1'b0;

    if (state == ST_IDLE && pending == 3'b000) pending_next = pend_sel;

    case (state)
      ST_IDLE: begin
        // Never launch on a strobe cycle so ISSUE sees a clean frame boundary.
        if (pending != 3'b000 && !update) begin
          state_next   = ST_ISSUE;
          pending_next = 3'b000;
          if (pending[2]) begin
            act_next    = ACT_DROP;
            remain_next = DROP_L;
          end else if (pending[0]) begin
            act_next    = ACT_BIG;
            remain_next = BIG_L;
          end else begin
            act_next    = ACT_SMALL;
            remain_next = SMALL_L;
          end
        end
      end
      ST_ISSUE, ST_ACTIVE: begin
        if (state == ST_ISSUE) operation = op_of(act);
        state_next = ST_ACTIVE;
        if (update) begin
          if (remain == 5'd1) begin
            remain_next = 5'd0;
            state_next  = ST_SETTLE;
          end else begin
            remain_next = remain - 5'd1;
          end
        end
      end
      ST_SETTLE: begin
        if (update) begin
          land_err   = (y_in != GROUND_Y);
          act_next   = ACT_NONE;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy        = (state != ST_IDLE);
  assign action      = act;
  assign frames_left = (state == ST_ISSUE || state == ST_ACTIVE) ? remain : 5'd0;

endmodule

// File: tb/tb_movement_controller.sv
// tb/tb_movement_controller.sv - scoreboard bench for movement_controller
module tb_movement_controller;

  logic       clk = 1'b0;
  logic       reset, game_en, key_big, key_small, key_drop;
  logic [6:0] y_in;
  logic       update, busy, land_err;
  logic [2:0] operation;
  logic [1:0] action;
  logic [4:0] frames_left;

  int errors = 0;
  int checks = 0;

  logic [2:0] exp_ops[$];
  logic [2:0] exp_op;
  logic [2:0] prev_op = 3'b000;
  bit         mon_en = 1'b0;

  movement_controller #(
    .TICK_DIV(4), .BIG_LEN(10), .SMALL_LEN(15), .DROP_LEN(9), .GROUND_Y(7'd108)
  ) dut (
    .clk(clk), .reset(reset), .game_en(game_en),
    .key_big(key_big), .key_small(key_small), .key_drop(key_drop),
    .y_in(y_in), .update(update), .operation(operation), .busy(busy),
    .action(action), .frames_left(frames_left), .land_err(land_err)
  );

  always #5 clk = ~clk;

  // Every issued operation is matched against the expectation queued at key press.
  always @(negedge clk) begin
    if (mon_en) begin
      if (operation !== 3'b000) begin
        checks++;
        if (prev_op !== 3'b000) begin
          errors++;
          $display("FAIL op_width: operation=%b follows %b, required a single-clk pulse", operation, prev_op);
        end else if (exp_ops.size() == 0) begin
          errors++;
          $display("FAIL op_unexpected: operation=%b, required none", operation);
        end else begin
          exp_op = exp_ops.pop_front();
          if (operation !== exp_op) begin
            errors++;
            $display("FAIL op_value: operation=%b, required %b", operation, exp_op);
          end
        end
      end
      prev_op = operation;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Follows one action to IDLE, modelling frames_left as decrementing on each strobe.
  task automatic observe(input int start_fl, output bit ok, output logic [1:0] act_seen,
                         output int n_upd, output int n_lerr, output int lerr_mis, output int fl_bad);
    int exp_fl;
    ok = 1'b0; n_upd = 0; n_lerr = 0; lerr_mis = 0; fl_bad = 0; act_seen = 2'b00;
    for (int i = 0; i < 20 && !busy; i++) step(1);
    if (!busy) return;
    act_seen = action;
    exp_fl = start_fl;
    for (int c = 0; c < 400; c++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      if (frames_left !== 5'(exp_fl)) fl_bad++;
      if (land_err) begin
        n_lerr++;
        if (!(update && exp_fl == 0)) lerr_mis++;
      end
      if (update) begin
        n_upd++;
        if (exp_fl > 0) exp_fl--;
      end
      step(1);
    end
  endtask

  task automatic test_reset;
    int n, last, sp_bad, idle_bad;
    reset = 1'b0; game_en = 1'b1; key_big = 1'b1; key_small = 1'b0; key_drop = 1'b0; y_in = 7'd108;
    step(3);
    checks++; if (update !== 1'b0) begin errors++; $display("FAIL rst_update: got %b, required 0", update); end
    checks++; if (operation !== 3'b000) begin errors++; $display("FAIL rst_operation: got %b, required 000", operation); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    checks++; if (action !== 2'b00) begin errors++; $display("FAIL rst_action: got %b, required 00", action); end
    checks++; if (frames_left !== 5'd0) begin errors++; $display("FAIL rst_frames_left: got %0d, required 0", frames_left); end
    checks++; if (land_err !== 1'b0) begin errors++; $display("FAIL rst_land_err: got %b, required 0", land_err); end
    key_big = 1'b0;
    step(1);
    reset = 1'b1;
    mon_en = 1'b1;
    n = 0; last = -1; sp_bad = 0; idle_bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (update) begin
        n++;
        if (last >= 0 && i - last != 4) sp_bad++;
        if (last < 0 && i != 3) sp_bad++;
        last = i;
      end
      if (busy || operation !== 3'b000) idle_bad++;
      step(1);
    end
    checks++; if (n != 4) begin errors++; $display("FAIL tick_count: got %0d pulses in 16 clks, required 4", n); end
    checks++; if (sp_bad != 0) begin errors++; $display("FAIL tick_spacing: got %0d bad gaps, required 0", sp_bad); end
    checks++; if (idle_bad != 0) begin errors++; $display("FAIL tick_idle: got %0d busy/op samples, required 0", idle_bad); end
  endtask

  task automatic test_big_held;
    bit ok; logic [1:0] a; int nu, nl, lm, fb;
    exp_ops.push_back(3'b001);
    key_big = 1'b1;
    fork begin step(20); key_big = 1'b0; end join_none
    observe(10, ok, a, nu, nl, lm, fb);
    checks++; if (!ok) begin errors++; $display("FAIL big_done: completed=%b, required 1", ok); end
    checks++; if (a !== 2'b01) begin errors++; $display("FAIL big_action: got %b, required 01", a); end
    checks++; if (nu != 11) begin errors++; $display("FAIL big_updates: got %0d, required 11", nu); end
    checks++; if (fb != 0) begin errors++; $display("FAIL big_frames: got %0d bad samples, required 0", fb); end
    checks++; if (nl != 0) begin errors++; $display("FAIL big_land_err: got %0d, required 0", nl); end
    step(20);
    checks++; if (busy !== 1'b0 || action !== 2'b00) begin errors++; $display("FAIL big_idle: busy=%b action=%b, required 0 00", busy, action); end
  endtask

  task automatic test_drop_priority;
    bit ok; logic [1:0] a; int nu, nl, lm, fb;
    exp_ops.push_back(3'b100);
    key_drop = 1'b1; key_small = 1'b1;
    fork begin
      step(3); key_drop = 1'b0; key_small = 1'b0;
      step(15); key_big = 1'b1;
      step(3); key_big = 1'b0;
    end join_none
    observe(9, ok, a, nu, nl, lm, fb);
    checks++; if (a !== 2'b11) begin errors++; $display("FAIL drop_action: got %b, required 11", a); end
    checks++; if (nu != 10 || !ok) begin errors++; $display("FAIL drop_updates: got %0d done=%b, required 10 1", nu, ok); end
    checks++; if (fb != 0) begin errors++; $display("FAIL drop_frames: got %0d bad samples, required 0", fb); end
    step(20);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_discard: busy=%b after idle, required 0", busy); end
  endtask

  task automatic test_pause;
    bit ok, found; logic [1:0] a; int nu, nl, lm, fb, ub, pb;
    exp_ops.push_back(3'b010);
    key_small = 1'b1; step(2); key_small = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (busy && frames_left === 5'd7) begin found = 1'b1; break; end
      step(1);
    end
    checks++; if (!found) begin errors++; $display("FAIL pause_reach: frames_left=%0d, required 7", frames_left); end
    game_en = 1'b0;
    ub = 0; pb = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (update) ub++;
      if (frames_left !== 5'd7 || !busy) pb++;
    end
    checks++; if (ub != 0) begin errors++; $display("FAIL pause_update: got %0d strobes, required 0", ub); end
    checks++; if (pb != 0) begin errors++; $display("FAIL pause_hold: got %0d drifted samples, required 0", pb); end
    game_en = 1'b1;
    observe(7, ok, a, nu, nl, lm, fb);
    checks++; if (a !== 2'b10) begin errors++; $display("FAIL pause_action: got %b, required 10", a); end
    checks++; if (nu != 8 || !ok) begin errors++; $display("FAIL pause_resume: got %0d updates done=%b, required 8 1", nu, ok); end
    checks++; if (fb != 0) begin errors++; $display("FAIL pause_frames: got %0d bad samples, required 0", fb); end
  endtask

  task automatic test_land_err;
    bit ok; logic [1:0] a; int nu, nl, lm, fb;
    int yv[2]  = '{110, 108};
    int exp[2] = '{1, 0};
    for (int r = 0; r < 2; r++) begin
      y_in = 7'(yv[r]);
      exp_ops.push_back(3'b001);
      key_big = 1'b1; step(2); key_big = 1'b0;
      observe(10, ok, a, nu, nl, lm, fb);
      checks++; if (nl != exp[r]) begin errors++; $display("FAIL land_err_y%0d: got %0d pulses, required %0d", yv[r], nl, exp[r]); end
      checks++; if (lm != 0) begin errors++; $display("FAIL land_err_place_y%0d: got %0d misplaced, required 0", yv[r], lm); end
      checks++; if (nu != 11 || !ok) begin errors++; $display("FAIL land_updates_y%0d: got %0d done=%b, required 11 1", yv[r], nu, ok); end
      step(3);
    end
    y_in = 7'd108;
  endtask

  task automatic test_reset_mid;
    bit ok, found; logic [1:0] a; int nu, nl, lm, fb;
    exp_ops.push_back(3'b001);
    key_big = 1'b1; step(2); key_big = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (busy && frames_left === 5'd4) begin found = 1'b1; break; end
      step(1);
    end
    checks++; if (!found) begin errors++; $display("FAIL rmid_reach: frames_left=%0d, required 4", frames_left); end
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b, required 0", busy); end
    checks++; if (action !== 2'b00) begin errors++; $display("FAIL rmid_action: got %b, required 00", action); end
    checks++; if (frames_left !== 5'd0) begin errors++; $display("FAIL rmid_frames: got %0d, required 0", frames_left); end
    checks++; if (operation !== 3'b000 || update !== 1'b0) begin errors++; $display("FAIL rmid_op: op=%b update=%b, required 000 0", operation, update); end
    step(2);
    reset = 1'b1;
    exp_ops.push_back(3'b010);
    key_small = 1'b1; step(2); key_small = 1'b0;
    observe(15, ok, a, nu, nl, lm, fb);
    checks++; if (a !== 2'b10) begin errors++; $display("FAIL rmid_small_action: got %b, required 10", a); end
    checks++; if (nu != 16 || !ok) begin errors++; $display("FAIL rmid_small_updates: got %0d done=%b, required 16 1", nu, ok); end
    checks++; if (fb != 0) begin errors++; $display("FAIL rmid_small_frames: got %0d bad samples, required 0", fb); end
  endtask

  task automatic test_back_to_back;
    bit ok; logic [1:0] a; int nu, nl, lm, fb;
    exp_ops.push_back(3'b010);
    key_small = 1'b1;
    observe(15, ok, a, nu, nl, lm, fb);
    step(30);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_reissue: busy=%b with key held, required 0", busy); end
    key_small = 1'b0;
    step(2);
    exp_ops.push_back(3'b001);
    key_big = 1'b1; step(1); key_big = 1'b0;
    observe(10, ok, a, nu, nl, lm, fb);
    checks++; if (a !== 2'b01 || nu != 11 || !ok) begin errors++; $display("FAIL b2b_big: action=%b updates=%0d done=%b, required 01 11 1", a, nu, ok); end
    step(5);
  endtask

  initial begin
    test_reset();
    test_big_held();
    test_drop_priority();
    test_pause();
    test_land_err();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_ops.size() != 0) begin
      errors++;
      $display("FAIL ops_outstanding: got %0d unissued, required 0", exp_ops.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
